// File: rtl/tx_8b10b_burst_sched.sv
// rtl/tx_8b10b_burst_sched.sv - burst framer feeding a combinational 8b/10b encoder; owns running disparity
// Optional periodic comma insertion in DATA: define TX_BURST_COMMA_INSERT_EN.
module tx_8b10b_burst_sched #(
  parameter int SYNC_LEN     = 4,
  parameter int MAX_FILL     = 16,
  parameter int COMMA_PERIOD = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] enc_data,
  output logic       enc_k,
  output logic       enc_rd_in,
  input  logic       enc_rd_out,
  output logic       sym_valid,
  output logic       busy,
  output logic       underrun_err
);

  localparam logic [7:0] SYM_SYNC  = 8'hBC;
  localparam logic [7:0] SYM_START = 8'hFB;
  localparam logic [7:0] SYM_END   = 8'hFD;
  localparam logic [7:0] SYM_FILL  = 8'h1C;

  if (SYNC_LEN < 1 || SYNC_LEN > 255 || MAX_FILL < 1 || MAX_FILL > 255 ||
      COMMA_PERIOD < 2 || COMMA_PERIOD > 1023) begin : g_bad_params
    $error("tx_8b10b_burst_sched: parameter out of range");
  end

  typedef enum logic [2:0] {IDLE, SYNC, SOB, DATA, EOB, FLUSH} state_t;

  state_t     state, state_nxt;
  logic [7:0] sync_cnt;
  logic [7:0] fill_cnt;
  logic       abort;
  logic       rd;
  logic       handshake;
  logic       sync_done;
  logic       fill_done;
  logic       comma_now;
  logic       sym_nxt;
  logic [7:0] data_nxt;
  logic       k_nxt;
  logic       underrun_nxt;

  assign handshake = s_valid & s_ready;
  assign sync_done = (sync_cnt == 8'(SYNC_LEN - 1));
  assign fill_done = (fill_cnt == 8'(MAX_FILL - 1));
  assign enc_rd_in = rd;

`ifdef TX_BURST_COMMA_INSERT_EN
  logic [9:0] comma_cnt;

  assign comma_now = (state == DATA) && (comma_cnt == 10'(COMMA_PERIOD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      comma_cnt <= 10'd0;
    end else if (state == SOB || comma_now) begin
      comma_cnt <= 10'd0;
    end else if (state == DATA && handshake && comma_cnt != 10'h3FF) begin
      comma_cnt <= comma_cnt + 10'd1;
    end
  end
`else
  assign comma_now = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (s_valid) state_nxt = SYNC;
      SYNC:  if (sync_done) state_nxt = SOB;
      SOB:   state_nxt = DATA;
      DATA: begin
        if (comma_now)                    state_nxt = DATA;
        else if (handshake && s_last)     state_nxt = EOB;
        else if (!handshake && fill_done) state_nxt = EOB;
      end
      EOB:   state_nxt = abort ? FLUSH : IDLE;
      FLUSH: if (handshake && s_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Each state's symbol choice is registered and shows on enc_* one cycle later.
  always_comb begin
    s_ready      = 1'b0;
    busy         = (state != IDLE);
    sym_nxt      = 1'b0;
    data_nxt     = enc_data;
    k_nxt        = enc_k;
    underrun_nxt = 1'b0;
    case (state)
      SYNC: begin
        sym_nxt  = 1'b1;
        data_nxt = SYM_SYNC;
        k_nxt    = 1'b1;
      end
      SOB: begin
        sym_nxt  = 1'b1;
        data_nxt = SYM_START;
        k_nxt    = 1'b1;
      end
      DATA: begin
        s_ready = !comma_now;
        sym_nxt = 1'b1;
        if (comma_now) begin
          data_nxt = SYM_SYNC;
          k_nxt    = 1'b1;
        end else if (handshake) begin
          data_nxt = s_data;
          k_nxt    = 1'b0;
        end else begin
          data_nxt     = SYM_FILL;
          k_nxt        = 1'b1;
          underrun_nxt = fill_done;
        end
      end
      EOB: begin
        sym_nxt  = 1'b1;
        data_nxt = SYM_END;
        k_nxt    = 1'b1;
      end
      FLUSH: s_ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_valid    <= 1'b0;
      enc_data     <= 8'h00;
      enc_k        <= 1'b0;
      underrun_err <= 1'b0;
      rd           <= 1'b0;
      sync_cnt     <= 8'd0;
      fill_cnt     <= 8'd0;
      abort        <= 1'b0;
    end else begin
      sym_valid    <= sym_nxt;
      enc_data     <= data_nxt;
      enc_k        <= k_nxt;
      underrun_err <= underrun_nxt;
      if (sym_valid) rd <= enc_rd_out;
      sync_cnt <= (state == SYNC && !sync_done) ? sync_cnt + 8'd1 : 8'd0;
      if (state == SOB) begin
        fill_cnt <= 8'd0;
      end else if (state == DATA && !comma_now) begin
        if (handshake)               fill_cnt <= 8'd0;
        else if (fill_cnt != 8'hFF)  fill_cnt <= fill_cnt + 8'd1;
      end
      if (underrun_nxt)                                abort <= 1'b1;
      else if (state == FLUSH && handshake && s_last)  abort <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tx_8b10b_burst_sched.sv
// tb/tb_tx_8b10b_burst_sched.sv - directed bench for tx_8b10b_burst_sched with a disparity-toggling encoder stub
module tb_tx_8b10b_burst_sched;

  logic       clk;
  logic       rst_n;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_ready;
  logic [7:0] enc_data;
  logic       enc_k;
  logic       enc_rd_in;
  logic       enc_rd_out;
  logic       sym_valid;
  logic       busy;
  logic       underrun_err;

  int   nvec = 0;
  int   nerr = 0;
  logic exp_rd;

  tx_8b10b_burst_sched #(
    .SYNC_LEN    (4),
    .MAX_FILL    (16),
    .COMMA_PERIOD(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .enc_data    (enc_data),
    .enc_k       (enc_k),
    .enc_rd_in   (enc_rd_in),
    .enc_rd_out  (enc_rd_out),
    .sym_valid   (sym_valid),
    .busy        (busy),
    .underrun_err(underrun_err)
  );

  assign enc_rd_out = !enc_rd_in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l);
    s_valid = v;
    s_data  = d;
    s_last  = l;
  endtask

  // Check the visible cycle, then advance one clock; the bench's rd flips after every expected symbol.
  task automatic cyc(input string tag, input logic ev, input logic [7:0] ed, input logic ek,
                     input logic erdy, input logic ebusy, input logic eund);
    chk({tag, ".sym_valid"}, 32'(sym_valid), 32'(ev));
    if (ev) begin
      chk({tag, ".enc_data"}, 32'(enc_data), 32'(ed));
      chk({tag, ".enc_k"}, 32'(enc_k), 32'(ek));
    end
    chk({tag, ".rd"}, 32'(enc_rd_in), 32'(exp_rd));
    chk({tag, ".s_ready"}, 32'(s_ready), 32'(erdy));
    chk({tag, ".busy"}, 32'(busy), 32'(ebusy));
    chk({tag, ".underrun"}, 32'(underrun_err), 32'(eund));
    if (ev) exp_rd = !exp_rd;
    tick();
  endtask

  // IDLE through the first DATA cycle, which accepts first_byte.
  task automatic preamble(input string t, input logic [7:0] first_byte);
    drive(1'b1, first_byte, 1'b0);
    cyc({t, ".idle"},  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc({t, ".sync0"}, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc({t, ".bc1"},   1'b1, 8'hBC, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc({t, ".bc2"},   1'b1, 8'hBC, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc({t, ".bc3"},   1'b1, 8'hBC, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc({t, ".bc4"},   1'b1, 8'hBC, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc({t, ".fb"},    1'b1, 8'hFB, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic pkt_clean(input string t);
    preamble(t, 8'h11);
    drive(1'b1, 8'h22, 1'b0);
    cyc({t, ".d11"}, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 8'h33, 1'b1);
    cyc({t, ".d22"}, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    cyc({t, ".d33"}, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc({t, ".fd"},  1'b1, 8'hFD, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc({t, ".end"}, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n  = 1'b0;
    exp_rd = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    tick();
    tick();
    chk("rst.sym_valid", 32'(sym_valid), 32'd0);
    chk("rst.enc_data", 32'(enc_data), 32'h00);
    chk("rst.enc_k", 32'(enc_k), 32'd0);
    chk("rst.s_ready", 32'(s_ready), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.underrun", 32'(underrun_err), 32'd0);
    chk("rst.rd", 32'(enc_rd_in), 32'd0);
    rst_n = 1'b1;

    pkt_clean("p1");

    preamble("fill", 8'h11);
    drive(1'b1, 8'h22, 1'b0);
    cyc("fill.d11", 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    cyc("fill.d22", 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("fill.f1",  1'b1, 8'h1C, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 8'h33, 1'b1);
    cyc("fill.f2",  1'b1, 8'h1C, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    cyc("fill.d33", 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("fill.fd",  1'b1, 8'hFD, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("fill.end", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    preamble("urun", 8'hA0);
    drive(1'b0, 8'h00, 1'b0);
    cyc("urun.da0", 1'b1, 8'hA0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) begin
      cyc($sformatf("urun.f%0d", i + 1), 1'b1, 8'h1C, 1'b1, 1'b1, 1'b1, 1'b0);
    end
    cyc("urun.f16", 1'b1, 8'h1C, 1'b1, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 8'hA1, 1'b0);
    cyc("urun.fd",  1'b1, 8'hFD, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 8'hA2, 1'b0);
    cyc("urun.fl2", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 8'hA3, 1'b0);
    cyc("urun.fl3", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 8'hA4, 1'b1);
    cyc("urun.fl4", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    cyc("urun.idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    preamble("mid", 8'h11);
    drive(1'b1, 8'h22, 1'b0);
    cyc("mid.d11", 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    exp_rd = 1'b0;
    chk("mid.sym_valid", 32'(sym_valid), 32'd0);
    chk("mid.enc_data", 32'(enc_data), 32'h00);
    chk("mid.enc_k", 32'(enc_k), 32'd0);
    chk("mid.s_ready", 32'(s_ready), 32'd0);
    chk("mid.busy", 32'(busy), 32'd0);
    chk("mid.rd", 32'(enc_rd_in), 32'd0);
    drive(1'b0, 8'h00, 1'b0);
    tick();
    rst_n = 1'b1;
    pkt_clean("p2");

`ifdef TX_BURST_COMMA_INSERT_EN
    preamble("cm", 8'h01);
    drive(1'b1, 8'h02, 1'b0);
    cyc("cm.d01", 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 8'h03, 1'b0);
    cyc("cm.d02", 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 8'h04, 1'b0);
    cyc("cm.d03", 1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 8'h05, 1'b0);
    cyc("cm.d04", 1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("cm.bc1", 1'b1, 8'hBC, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 8'h06, 1'b0);
    cyc("cm.d05", 1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 8'h07, 1'b0);
    cyc("cm.d06", 1'b1, 8'h06, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 8'h08, 1'b0);
    cyc("cm.d07", 1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 8'h09, 1'b0);
    cyc("cm.d08", 1'b1, 8'h08, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("cm.bc2", 1'b1, 8'hBC, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 8'h0A, 1'b1);
    cyc("cm.d09", 1'b1, 8'h09, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    cyc("cm.d0a", 1'b1, 8'h0A, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("cm.fd",  1'b1, 8'hFD, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("cm.end", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
